// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic unit (divider side).
//
// Contents:
//   DEFAULT_WIDTH  default operand / quotient / remainder width in bits.
//   cnt_width()    width of an iteration counter that must hold the value
//                  WIDTH itself, i.e. clog2(WIDTH+1).
//   div_state_t    control FSM states of the sequential divider.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // The counter is loaded with WIDTH (not WIDTH-1), so it needs one value
    // more than a plain index into the operand.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One combinational iteration of restoring division.
//
// The partial remainder A is shifted left one place, taking in the top bit of
// the dividend/quotient register Q. The divisor M is trial-subtracted. If the
// difference is non-negative it becomes the new A and a 1 enters the quotient.
// Otherwise the shifted value is kept (the "restore") and a 0 enters it.
//
// Ports:
//   a       in   WIDTH+1  current partial remainder
//   q       in   WIDTH    dividend bits not yet consumed / quotient so far
//   m       in   WIDTH    divisor
//   a_next  out  WIDTH+1  partial remainder after this iteration
//   q_next  out  WIDTH    Q shifted left with the new quotient bit in bit 0
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // A always stays below M, so A[WIDTH] is zero between iterations. It is
    // dropped by the shift and is only carried for the register's width.
    logic unused_a_msb;
    assign unused_a_msb = a[WIDTH];

    assign shifted = {a[WIDTH-1:0], q[WIDTH-1]};

    // Since shifted <= 2M-1, a non-negative difference is below M < 2^WIDTH.
    // Bit WIDTH of the difference is therefore a correct borrow/sign flag.
    assign trial = shifted - {1'b0, m};

    always_comb begin
        if (!trial[WIDTH]) begin
            a_next = trial;
            q_next = {q[WIDTH-2:0], 1'b1};
        end else begin
            a_next = shifted;
            q_next = {q[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned divider, one restoring-division iteration per clock.
// It uses a start/done handshake that matches the shift/add multiplier, so
// both can sit in the same arithmetic unit.
//
// Ports:
//   clk          in   1      rising-edge clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      request a division; only looked at in IDLE
//   dividend     in   WIDTH  unsigned dividend, captured with start
//   divisor      in   WIDTH  unsigned divisor, captured with start
//   busy         out  1      high while iterating (RUN)
//   done         out  1      single-cycle pulse, results valid
//   quotient     out  WIDTH  result, held until the next completion
//   remainder    out  WIDTH  result, held until the next completion
//   div_by_zero  out  1      set with done when divisor was 0, held
//
// Timing: start is sampled at edge E0. done is high in the cycle after edge
// E0+WIDTH. It is high in the cycle after E0 when the divisor is zero.
// After done the FSM spends one cycle in DONE and then returns to IDLE.
// A start that is held high is therefore taken again one cycle after done.
module restoring_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_t       state_reg, state_next;
    logic [WIDTH:0]   a_reg, a_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic [WIDTH-1:0] m_reg, m_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;

    logic [WIDTH:0]   step_a;
    logic [WIDTH-1:0] step_q;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .m      (m_reg),
        .a_next (step_a),
        .q_next (step_q)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            q_reg         <= '0;
            m_reg         <= '0;
            count_reg     <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            a_reg         <= a_next;
            q_reg         <= q_next;
            m_reg         <= m_next;
            count_reg     <= count_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_next     = state_reg;
        a_next         = a_reg;
        q_next         = q_reg;
        m_next         = m_reg;
        count_next     = count_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;

        unique case (state_reg)
            IDLE: begin
                if (start) begin
                    if (divisor != '0) begin
                        a_next     = '0;
                        q_next     = dividend;
                        m_next     = divisor;
                        count_next = CNT_W'(WIDTH);
                        busy_next  = 1'b1;
                        state_next = RUN;
                    end else begin
                        // Divide by zero skips the iterations. It returns
                        // all-ones and passes the dividend through.
                        quotient_next  = '1;
                        remainder_next = dividend;
                        dbz_next       = 1'b1;
                        done_next      = 1'b1;
                        state_next     = DONE;
                    end
                end
            end

            RUN: begin
                a_next     = step_a;
                q_next     = step_q;
                count_next = count_reg - CNT_W'(1);
                if (count_reg == CNT_W'(1)) begin
                    // div_by_zero belongs to the visible result set. It is
                    // cleared here, at completion, so that the previous
                    // result stays intact for the whole operation.
                    quotient_next  = step_q;
                    remainder_next = step_a[WIDTH-1:0];
                    dbz_next       = 1'b0;
                    done_next      = 1'b1;
                    busy_next      = 1'b0;
                    state_next     = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_restoring_divider.sv
module tb_restoring_divider;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    restoring_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dd;
        logic [W-1:0] dv;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, " busy"}, {31'd0, busy}, 0);
        chk({tag, " done"}, {31'd0, done}, 0);
        chk({tag, " quotient"}, {16'd0, quotient}, 0);
        chk({tag, " remainder"}, {16'd0, remainder}, 0);
        chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, 0);
    endtask

    // Launch one operation with a single-cycle start pulse.
    // lat is the number of edges after the sampling edge until done is seen.
    // bcnt is the number of cycles with busy high over the same window.
    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                          output logic [W-1:0] gq, output logic [W-1:0] gr,
                          output logic gz, output int lat, output int bcnt);
        int n;
        @(posedge clk); #1;
        start = 1'b1; dividend = dd; divisor = dv;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; bcnt = 0; n = 0;
        gq = '0; gr = '0; gz = 1'b0;
        while (lat < 0 && n < 100) begin
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                gq  = quotient;
                gr  = remainder;
                gz  = div_by_zero;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] gq, gr;
        logic         gz;
        int           lat, bcnt, exp_lat, ndone, ops, cyc, done_cyc;
        logic         pulse_next, busy_prev;
        logic [W-1:0] cur_dd, cur_dv, pend_dd, pend_dv;

        vecs[0]  = '{16'd100,   16'd7,      16'd14,    16'd2,    1'b0};
        vecs[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,  16'd0,    1'b0};
        vecs[2]  = '{16'd5,     16'd9,      16'd0,     16'd5,    1'b0};
        vecs[3]  = '{16'd1234,  16'd0,      16'hFFFF,  16'd1234, 1'b1};
        vecs[4]  = '{16'hFFFF,  16'hFFFF,   16'd1,     16'd0,    1'b0};
        vecs[5]  = '{16'd0,     16'd5,      16'd0,     16'd0,    1'b0};
        vecs[6]  = '{16'd1000,  16'd10,     16'd100,   16'd0,    1'b0};
        vecs[7]  = '{16'd65535, 16'd2,      16'd32767, 16'd1,    1'b0};
        vecs[8]  = '{16'h8000,  16'h8000,   16'd1,     16'd0,    1'b0};
        vecs[9]  = '{16'd1,     16'hFFFF,   16'd0,     16'd1,    1'b0};
        vecs[10] = '{16'hFFFF,  16'h0100,   16'd255,   16'd255,  1'b0};
        vecs[11] = '{16'd12345, 16'd123,    16'd100,   16'd45,   1'b0};

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n = 1'b1;

        // Table-driven single operations
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].dd, vecs[i].dv, gq, gr, gz, lat, bcnt);
            exp_lat = (vecs[i].dv == 0) ? 0 : W;
            $display("op %0d: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d busy=%0d",
                     i, vecs[i].dd, vecs[i].dv, gq, gr, gz, lat, bcnt);
            chk($sformatf("vec%0d quotient", i), {16'd0, gq}, {16'd0, vecs[i].q});
            chk($sformatf("vec%0d remainder", i), {16'd0, gr}, {16'd0, vecs[i].r});
            chk($sformatf("vec%0d div_by_zero", i), {31'd0, gz}, {31'd0, vecs[i].z});
            chk($sformatf("vec%0d latency", i), lat, exp_lat);
            chk($sformatf("vec%0d busy cycles", i), bcnt, exp_lat);
            @(posedge clk); #1;
            chk($sformatf("vec%0d done width", i), {31'd0, done}, 0);
        end

        // Starts during RUN and DONE are ignored; the old result stays visible
        @(posedge clk); #1;
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; pulse_next = 1'b0; gq = '0; gr = '0;
        for (int n = 0; n < 30; n++) begin
            if (n == 3) chk("held quotient", {16'd0, quotient}, {16'd0, vecs[NV-1].q});
            if (n == 5) begin start = 1'b1; dividend = 16'd50; divisor = 16'd5; end
            if (n == 6) start = 1'b0;
            if (done) begin
                ndone++;
                gq = quotient; gr = remainder;
                chk("ignore latency", n, W);
                start = 1'b1; dividend = 16'd50; divisor = 16'd5;
                pulse_next = 1'b1;
            end else if (pulse_next) begin
                start = 1'b0;
                pulse_next = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        $display("ignore: dones=%0d q=%0d r=%0d", ndone, gq, gr);
        chk("ignore done count", ndone, 1);
        chk("ignore quotient", {16'd0, gq}, 14);
        chk("ignore remainder", {16'd0, gr}, 2);
        chk("ignore idle busy", {31'd0, busy}, 0);

        // Asynchronous reset in the middle of an operation
        @(posedge clk); #1;
        start = 1'b1; dividend = 16'hABCD; divisor = 16'h0123;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        $display("reset mid-op: q=%0h r=%0h busy=%0d", quotient, remainder, busy);
        chk_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("midreset no done", ndone, 0);
        run_op(16'hFFFF, 16'hFFFF, gq, gr, gz, lat, bcnt);
        $display("post-reset op: q=%0d r=%0d lat=%0d", gq, gr, lat);
        chk("post-reset quotient", {16'd0, gq}, 1);
        chk("post-reset remainder", {16'd0, gr}, 0);
        chk("post-reset latency", lat, W);

        // Back-to-back operations with start held high. Operands are scrambled
        // right after each acceptance, which also shows that they are not
        // re-sampled while the divider runs.
        @(posedge clk); #1;
        pend_dd = 16'($urandom); pend_dv = 16'($urandom_range(1, 65535));
        dividend = pend_dd; divisor = pend_dv; start = 1'b1;
        cur_dd = '0; cur_dv = 16'd1;
        ops = 0; cyc = 0; done_cyc = 0; busy_prev = 1'b0;
        while (ops < 8 && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
            if (busy && !busy_prev) begin
                cur_dd = pend_dd; cur_dv = pend_dv;
                if (ops > 0) chk($sformatf("b2b%0d accept gap", ops), cyc - done_cyc, 2);
                pend_dd = 16'($urandom); pend_dv = 16'($urandom_range(1, 65535));
                dividend = pend_dd; divisor = pend_dv;
            end
            if (done) begin
                $display("b2b %0d: %0d / %0d -> q=%0d r=%0d", ops, cur_dd, cur_dv, quotient, remainder);
                chk($sformatf("b2b%0d quotient", ops), {16'd0, quotient}, {16'd0, cur_dd / cur_dv});
                chk($sformatf("b2b%0d remainder", ops), {16'd0, remainder}, {16'd0, cur_dd % cur_dv});
                ops++;
                done_cyc = cyc;
                if (ops == 8) start = 1'b0;
            end
            busy_prev = busy;
        end
        start = 1'b0;
        chk("b2b op count", ops, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
